// File: rtl/cross_bar_pkg.sv
// rtl/cross_bar_pkg.sv - shared constants, port index type and round-robin pick for the 4x4 crossbar
package cross_bar_pkg;

    localparam int N_DEFAULT = 32;
    localparam int NP        = 4;

    typedef logic [1:0] port_idx_t;

    // First requester after 'last', wrapping; 'last' itself is tried last.
    function automatic port_idx_t rr_pick(logic [NP-1:0] req, port_idx_t last);
        port_idx_t idx;
        rr_pick = last + 2'd1;
        for (int i = NP; i >= 1; i--) begin
            idx = last + port_idx_t'(i);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/cross_bar_if.sv
// rtl/cross_bar_if.sv - request/ack bus between a master and a slave
interface cross_bar_if #(
    parameter int N = cross_bar_pkg::N_DEFAULT
);

    logic         req;
    logic [N-1:0] addr;
    logic         cmd;
    logic [N-1:0] wdata;
    logic         ack;
    logic [N-1:0] rdata;

    modport master (
        output req, addr, cmd, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, addr, cmd, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/cross_bar_arbiter.sv
// rtl/cross_bar_arbiter.sv - 4-way round-robin arbiter, pointer moves only on a completed handshake
module cross_bar_arbiter
    import cross_bar_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [NP-1:0] req_i,
    input  logic          hs_i,
    output logic [NP-1:0] gnt_o,
    output port_idx_t     idx_o
);

    port_idx_t ptr_q;
    port_idx_t ptr_d;

    always_comb begin
        idx_o = rr_pick(req_i, ptr_q);
        gnt_o = '0;
        if (|req_i) begin
            gnt_o[idx_o] = 1'b1;
        end
        ptr_d = hs_i ? idx_o : ptr_q;
    end

    // Reset to the last index so master 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= port_idx_t'(NP - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cross_bar.sv
// rtl/cross_bar.sv - 4x4 address-decoded crossbar with per-slave round-robin and 1-cycle read return
module cross_bar
    import cross_bar_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    cross_bar_if.slave  m_bus [NP],
    cross_bar_if.master s_bus [NP]
);

    logic [NP-1:0] m_req;
    logic [NP-1:0] m_cmd;
    logic [N-1:0]  m_addr  [NP];
    logic [N-1:0]  m_wdata [NP];
    port_idx_t     m_tgt   [NP];
    logic [NP-1:0] m_ack;
    logic [N-1:0]  m_rdata [NP];

    logic [NP-1:0] s_req;
    logic [NP-1:0] s_cmd;
    logic [N-1:0]  s_addr  [NP];
    logic [N-1:0]  s_wdata [NP];
    logic [NP-1:0] s_ack;
    logic [N-1:0]  s_rdata [NP];

    logic [NP-1:0] arb_req [NP];
    logic [NP-1:0] arb_gnt [NP];
    port_idx_t     arb_idx [NP];
    logic [NP-1:0] hs;

    logic [NP-1:0] rd_pend_q;
    logic [NP-1:0] rd_pend_d;
    port_idx_t     rd_sel_q [NP];
    port_idx_t     rd_sel_d [NP];

    for (genvar k = 0; k < NP; k++) begin : g_m
        assign m_req[k]       = m_bus[k].req;
        assign m_cmd[k]       = m_bus[k].cmd;
        assign m_addr[k]      = m_bus[k].addr;
        assign m_wdata[k]     = m_bus[k].wdata;
        assign m_tgt[k]       = port_idx_t'(m_bus[k].addr[N-1 -: 2]);
        assign m_bus[k].ack   = m_ack[k];
        assign m_bus[k].rdata = m_rdata[k];
    end

    for (genvar j = 0; j < NP; j++) begin : g_s
        assign s_bus[j].req   = s_req[j];
        assign s_bus[j].cmd   = s_cmd[j];
        assign s_bus[j].addr  = s_addr[j];
        assign s_bus[j].wdata = s_wdata[j];
        assign s_ack[j]       = s_bus[j].ack;
        assign s_rdata[j]     = s_bus[j].rdata;

        cross_bar_arbiter u_arb (
            .clk   (clk),
            .rst   (rst),
            .req_i (arb_req[j]),
            .hs_i  (hs[j]),
            .gnt_o (arb_gnt[j]),
            .idx_o (arb_idx[j])
        );
    end

    always_comb begin : req_route
        for (int j = 0; j < NP; j++) begin
            for (int k = 0; k < NP; k++) begin
                arb_req[j][k] = m_req[k] && (m_tgt[k] == port_idx_t'(j));
            end
        end
    end

    // Idle slaves see an all-zero request, not the last granted master's fields.
    always_comb begin : slave_fwd
        for (int j = 0; j < NP; j++) begin
            s_req[j]   = |arb_req[j];
            s_cmd[j]   = 1'b0;
            s_addr[j]  = '0;
            s_wdata[j] = '0;
            if (|arb_req[j]) begin
                s_cmd[j]   = m_cmd[arb_idx[j]];
                s_addr[j]  = m_addr[arb_idx[j]];
                s_wdata[j] = m_wdata[arb_idx[j]];
            end
            hs[j] = (|arb_req[j]) && s_ack[j];
        end
    end

    always_comb begin : master_side
        for (int k = 0; k < NP; k++) begin
            m_ack[k]     = m_req[k] && arb_gnt[m_tgt[k]][k] && s_ack[m_tgt[k]];
            rd_pend_d[k] = m_ack[k] && !m_cmd[k];
            rd_sel_d[k]  = rd_pend_d[k] ? m_tgt[k] : rd_sel_q[k];
            m_rdata[k]   = rd_pend_q[k] ? s_rdata[rd_sel_q[k]] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q <= '0;
            rd_sel_q  <= '{default: '0};
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_sel_q  <= rd_sel_d;
        end
    end

endmodule

// File: tb/tb_cross_bar.sv
// tb/tb_cross_bar.sv - scoreboard bench for cross_bar: directed vectors plus permuted random traffic
module tb_cross_bar;
    import cross_bar_pkg::*;

    localparam logic [31:0] JUNK = 32'h5A5A_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cross_bar_if m_bus [NP] ();
    cross_bar_if s_bus [NP] ();

    logic [NP-1:0] mreq, mcmd, mack, sreq, scmd, sack;
    logic [31:0]   maddr [NP], mwdata [NP], mrdata [NP];
    logic [31:0]   saddr [NP], swdata [NP], srdata [NP];
    logic [31:0]   nxt   [NP];

    for (genvar g = 0; g < NP; g++) begin : g_conn
        assign m_bus[g].req   = mreq[g];
        assign m_bus[g].cmd   = mcmd[g];
        assign m_bus[g].addr  = maddr[g];
        assign m_bus[g].wdata = mwdata[g];
        assign mack[g]        = m_bus[g].ack;
        assign mrdata[g]      = m_bus[g].rdata;
        assign sreq[g]        = s_bus[g].req;
        assign scmd[g]        = s_bus[g].cmd;
        assign saddr[g]       = s_bus[g].addr;
        assign swdata[g]      = s_bus[g].wdata;
        assign s_bus[g].ack   = sack[g];
        assign s_bus[g].rdata = srdata[g];
    end

    cross_bar #(.N(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .m_bus (m_bus),
        .s_bus (s_bus)
    );

    typedef struct {
        int          k;
        logic [31:0] addr;
        logic        cmd;
        logic [31:0] wdata;
        logic        ack;
        logic        ret;
    } fwd_t;

    fwd_t        fwd_q [NP][$];
    logic [31:0] rd_q  [NP][$];
    logic [NP-1:0] pend = '0;
    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endfunction

    task automatic monitor();
        logic [NP-1:0] ack_exp;
        logic [NP-1:0] pend_n;
        fwd_t r;
        ack_exp = '0;
        pend_n  = '0;
        for (int j = 0; j < NP; j++) begin
            if (sreq[j]) begin
                if (fwd_q[j].size() == 0) begin
                    chk($sformatf("s%0d_unexpected_req", j), 32'(sreq[j]), 32'd0);
                end else begin
                    r = fwd_q[j].pop_front();
                    chk($sformatf("s%0d_addr", j), saddr[j], r.addr);
                    chk($sformatf("s%0d_cmd", j), 32'(scmd[j]), 32'(r.cmd));
                    chk($sformatf("s%0d_wdata", j), swdata[j], r.wdata);
                    ack_exp[r.k] = ack_exp[r.k] | r.ack;
                    if (r.ack && !r.cmd && r.ret && !rst) pend_n[r.k] = 1'b1;
                end
            end else begin
                chk($sformatf("s%0d_idle_fields", j), saddr[j] | swdata[j] | 32'(scmd[j]), 32'd0);
            end
        end
        for (int k = 0; k < NP; k++) begin
            chk($sformatf("m%0d_ack", k), 32'(mack[k]), 32'(ack_exp[k]));
            if (pend[k] && rd_q[k].size() != 0) begin
                chk($sformatf("m%0d_rdata", k), mrdata[k], rd_q[k].pop_front());
            end else begin
                chk($sformatf("m%0d_rdata_idle", k), mrdata[k], 32'd0);
            end
        end
        pend = pend_n;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor();
        end
    end

    task automatic drv(int k, logic req, logic cmd, logic [31:0] addr, logic [31:0] wd);
        mreq[k]   = req;
        mcmd[k]   = cmd;
        maddr[k]  = addr;
        mwdata[k] = wd;
    endtask

    task automatic exp_fwd(int j, int k, logic ack, logic ret, logic [31:0] rdv);
        fwd_t r;
        r.k     = k;
        r.addr  = maddr[k];
        r.cmd   = mcmd[k];
        r.wdata = mwdata[k];
        r.ack   = ack;
        r.ret   = ret;
        fwd_q[j].push_back(r);
        if (ack && !mcmd[k] && ret) begin
            nxt[j] = rdv;
            rd_q[k].push_back(rdv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int j = 0; j < NP; j++) begin
            srdata[j] = nxt[j];
            nxt[j]    = JUNK | 32'(j);
        end
    endtask

    initial begin
        int          j;
        logic [1:0]  rot;
        mreq = '0;
        mcmd = '0;
        sack = '1;
        for (int k = 0; k < NP; k++) begin
            maddr[k]  = '0;
            mwdata[k] = '0;
            srdata[k] = JUNK | 32'(k);
            nxt[k]    = JUNK | 32'(k);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();

        // single write to slave 3
        drv(0, 1'b1, 1'b1, 32'hC000_0010, 32'h1234_5678);
        exp_fwd(3, 0, 1'b1, 1'b0, 32'd0);
        tick();
        mreq = '0;
        tick();

        // single read from slave 1, data one cycle after ack
        drv(1, 1'b1, 1'b0, 32'h4000_0004, 32'd0);
        exp_fwd(1, 1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        tick();
        mreq = '0;
        tick();

        // all masters read slave 0: m0,m1,m2,m3,m0
        for (int k = 0; k < NP; k++) drv(k, 1'b1, 1'b0, 32'h0, 32'h100 + 32'(k));
        for (int c = 0; c < 5; c++) begin
            exp_fwd(0, c % 4, 1'b1, 1'b1, 32'hA000_0000 + 32'(c));
            tick();
        end
        mreq = '0;
        tick();

        // four disjoint writes in one cycle
        drv(0, 1'b1, 1'b1, 32'h8000_0020, 32'h0000_00A0);
        drv(1, 1'b1, 1'b1, 32'hC000_0030, 32'h0000_00A1);
        drv(2, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_00A2);
        drv(3, 1'b1, 1'b1, 32'h4000_0050, 32'h0000_00A3);
        exp_fwd(2, 0, 1'b1, 1'b0, 32'd0);
        exp_fwd(3, 1, 1'b1, 1'b0, 32'd0);
        exp_fwd(0, 2, 1'b1, 1'b0, 32'd0);
        exp_fwd(1, 3, 1'b1, 1'b0, 32'd0);
        tick();
        mreq = '0;
        tick();

        // slave 2 stalls 3 cycles; m2 keeps grant over m0, then m0 follows
        drv(2, 1'b1, 1'b1, 32'h8000_0100, 32'hCAFE_0002);
        drv(0, 1'b1, 1'b1, 32'h8000_0200, 32'hCAFE_0000);
        sack[2] = 1'b0;
        repeat (3) begin
            exp_fwd(2, 2, 1'b0, 1'b0, 32'd0);
            tick();
        end
        sack[2] = 1'b1;
        exp_fwd(2, 2, 1'b1, 1'b0, 32'd0);
        tick();
        mreq[2] = 1'b0;
        exp_fwd(2, 0, 1'b1, 1'b0, 32'd0);
        tick();
        mreq = '0;
        tick();

        // read handshake then reset: return is discarded, slave 0 pointer back to master 0 priority
        drv(3, 1'b1, 1'b0, 32'h4000_0000, 32'd0);
        exp_fwd(1, 3, 1'b1, 1'b0, 32'd0);
        tick();
        mreq = '0;
        rst  = 1'b1;
        drv(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0B01);
        drv(3, 1'b1, 1'b0, 32'h0000_000C, 32'h0000_0B03);
        sack[0] = 1'b0;
        exp_fwd(0, 1, 1'b0, 1'b0, 32'd0);
        tick();
        rst     = 1'b0;
        sack[0] = 1'b1;
        exp_fwd(0, 1, 1'b1, 1'b1, 32'h1111_0001);
        tick();
        exp_fwd(0, 3, 1'b1, 1'b1, 32'h3333_0003);
        tick();
        mreq = '0;
        tick();

        // random traffic, one master per slave per cycle
        for (int c = 0; c < 64; c++) begin
            rot = 2'($urandom_range(0, 3));
            for (int k = 0; k < NP; k++) begin
                j = int'(2'(k) + rot);
                drv(k, 1'b1, 1'($urandom_range(0, 1)), {2'(j), 30'($urandom)}, $urandom);
                exp_fwd(j, k, 1'b1, 1'b1, $urandom);
            end
            tick();
        end
        mreq = '0;
        tick();
        tick();

        for (int k = 0; k < NP; k++) begin
            chk($sformatf("s%0d_fwd_left", k), 32'(fwd_q[k].size()), 32'd0);
            chk($sformatf("m%0d_rd_left", k), 32'(rd_q[k].size()), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cross_bar.md
CROSS_BAR -- requirements
Module: cross_bar

Interface
REQ-001 Parameter: N, default Nr (32), address/data bus width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m_bus[3:0]  BUS array, slave-side view  4 master ports; each carries req (in, 1), addr (in, N), cmd (in, 1; 1=write, 0=read), wdata (in, N), ack (out, 1), rdata (out, N).
REQ-005 s_bus[3:0]  BUS array, master-side view  4 slave ports; each carries req (out, 1), addr (out, N), cmd (out, 1), wdata (out, N), ack (in, 1), rdata (in, N).

Function
REQ-006 Target slave of master k SHALL be m_bus[k].addr[N-1:N-2]; 00→s_bus[0] … 11→s_bus[3].
REQ-007 Each slave SHALL have an independent arbiter choosing, combinationally, one requesting master among those targeting it.
REQ-008 Arbitration SHALL be round-robin: search starts at the master after the last master granted a completed handshake on that slave; if that master does not request, the next index mod 4 is tried.
REQ-009 Pointer SHALL advance only on a completed slave handshake (s_bus[j].req && s_bus[j].ack); without a handshake the same master keeps the grant.
REQ-010 Granted master's req, addr (full N bits, unmodified), cmd and wdata SHALL drive s_bus[j] combinationally (zero-latency forward).
REQ-011 Slave with no requesting master SHALL drive req=0, cmd=0, addr=0, wdata=0.
REQ-012 m_bus[k].ack SHALL equal s_bus[j].ack combinationally when master k is granted on slave j and requesting; otherwise 0.
REQ-013 A master that is not requesting SHALL never see ack=1.
REQ-014 Read handshake (req && ack && cmd=0) SHALL register the target slave index per master and set a per-master read-pending flag for the next cycle.
REQ-015 In the cycle after a read handshake, m_bus[k].rdata SHALL equal s_bus[registered slave].rdata (combinational mux from registered select); read latency = 1 cycle after ack.
REQ-016 With no read pending, m_bus[k].rdata SHALL be 0.
REQ-017 Back-to-back operations SHALL be supported: a master may issue a new request in the same cycle its previous read data is returned; flag/select are overwritten by the new handshake.
REQ-018 Different masters targeting different slaves SHALL proceed concurrently in the same cycle with no interaction.
REQ-019 Write handshake (cmd=1) SHALL not set the read-pending flag.

Reset
REQ-020 While reset=1: all round-robin pointers SHALL point so master 0 has priority, all read-pending flags and registered selects SHALL be 0.
REQ-021 During reset all s_bus outputs and m_bus ack/rdata SHALL follow the combinational rules from reset state state (rdata=0); assertion mid-transfer SHALL discard pending read returns.

Structure
REQ-022 Shared package cross_bar_pkg SHALL hold N default, port count (4) and the 2-bit port-index type.
REQ-023 One sub-module cross_bar_arbiter (4-input round-robin, grant one-hot, advance on handshake) SHALL be instantiated once per slave.

Verification
REQ-024 Single write: m0 req=1, cmd=1, addr=0xC0000010, wdata=0x12345678, slave acks immediately -> s_bus[3] shows same req/cmd/addr/wdata, m0 ack=1 same cycle.
REQ-025 Single read: m1 read addr=0x40000004, s_bus[1].rdata=0xDEADBEEF -> m1 ack in cycle T, m1 rdata=0xDEADBEEF in cycle T+1.
REQ-026 Contention: m0..m3 all read addr 0x00000000 continuously after reset -> grants on s_bus[0] in order m0,m1,m2,m3,m0; exactly one ack per cycle.
REQ-027 Parallel: m0→slave2, m1→slave3, m2→slave0, m3→slave1 writes -> all four acks in the same cycle, each slave sees its own master's data.
REQ-028 Slave stall: s_bus[2].ack=0 for 3 cycles with m2 requesting -> m2 ack=0, s_bus[2] holds m2's fields, grant unchanged; ack on cycle 4.
REQ-029 Idle/ack integrity: no master requesting -> all s_bus req=0, all m_bus ack=0; random 64-vector traffic per master with immediate slave ack -> every write forward and read return matches.
